// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants: bus widths, chip-enable levels, ROM depth and stall-vector bit positions.
package if_fetch_pkg;
   localparam int          InstAddrBus    = 32;
   localparam int          InstBus        = 32;
   localparam logic [31:0] ZeroWord       = 32'h0000_0000;
   localparam logic        ChipEnable     = 1'b1;
   localparam logic        ChipDisable    = 1'b0;
   localparam int          InstMemNumLog2 = 10;
   localparam int          StallPc        = 0;
   localparam int          StallIf        = 1;
   localparam int          StallId        = 2;
   localparam logic [31:0] DefResetPc     = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: control/stall inputs, ROM port and IF/ID latch outputs.
// FETCH_ALIGN_CHECK_EN adds the misaligned-fetch exception flag.
interface if_fetch_if #(parameter int ADDR_W = 32);
   logic [5:0]        stall;
   logic              flush;
   logic [ADDR_W-1:0] new_pc;
   logic              branch_flag_i;
   logic [ADDR_W-1:0] branch_target_i;
   logic [31:0]       rom_inst_i;
   logic [ADDR_W-1:0] rom_addr_o;
   logic              rom_en_o;
   logic [ADDR_W-1:0] id_pc_o;
   logic [31:0]       id_inst_o;
   logic              id_valid_o;
`ifdef FETCH_ALIGN_CHECK_EN
   logic              if_excp_adel_o;

   modport master (input stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
                   output rom_addr_o, rom_en_o, id_pc_o, id_inst_o, id_valid_o, if_excp_adel_o);
   modport slave  (output stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
                   input rom_addr_o, rom_en_o, id_pc_o, id_inst_o, id_valid_o, if_excp_adel_o);
`else
   modport master (input stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
                   output rom_addr_o, rom_en_o, id_pc_o, id_inst_o, id_valid_o);
   modport slave  (output stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
                   input rom_addr_o, rom_en_o, id_pc_o, id_inst_o, id_valid_o);
`endif
endinterface

// File: rtl/fetch_pc_reg.sv
// PC register with ROM chip enable and next-PC selection (flush > stall > branch > pc+4).
module fetch_pc_reg
   import if_fetch_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_pc,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              rom_en
);
   logic [ADDR_W-1:0] pc_next;

   always_comb begin
      pc_next = pc + ADDR_W'(4);
      if (flush)            pc_next = new_pc;
      else if (stall_pc)    pc_next = pc;
      else if (branch_flag) pc_next = branch_target;
   end

   // The enable comes up one edge after reset release; PC stays put on that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         rom_en <= ChipDisable;
      end else begin
         rom_en <= ChipEnable;
         if (rom_en == ChipEnable) pc <= pc_next;
      end
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC/ROM drive via fetch_pc_reg plus the IF/ID latch.
// FETCH_ALIGN_CHECK_EN enables the misaligned-PC exception flag.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DefResetPc[ADDR_W-1:0]
) (
   input logic        clk,
   input logic        rst,
   if_fetch_if.master bus
);
   logic [ADDR_W-1:0] pc;
   logic              rom_en;
   logic [ADDR_W-1:0] id_pc;
   logic [31:0]       id_inst;
   logic              id_valid;
   logic              bubble;
   logic              unused_stall;

   assign unused_stall = ^bus.stall[5:3];

   fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
      .clk           (clk),
      .rst           (rst),
      .stall_pc      (bus.stall[StallPc]),
      .flush         (bus.flush),
      .new_pc        (bus.new_pc),
      .branch_flag   (bus.branch_flag_i),
      .branch_target (bus.branch_target_i),
      .pc            (pc),
      .rom_en        (rom_en)
   );

   // Stall of IF with ID free inserts a bubble; stall of both holds the latch.
   assign bubble = bus.flush
                || (bus.stall[StallIf] && !bus.stall[StallId])
                || (!bus.stall[StallIf] && rom_en == ChipDisable);

`ifdef FETCH_ALIGN_CHECK_EN
   logic adel;
   logic misaligned;
   assign misaligned = (pc[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc <= '0; id_inst <= ZeroWord; id_valid <= 1'b0; adel <= 1'b0;
      end else if (bubble) begin
         id_pc <= '0; id_inst <= ZeroWord; id_valid <= 1'b0; adel <= 1'b0;
      end else if (!bus.stall[StallIf]) begin
         id_pc    <= pc;
         id_inst  <= misaligned ? ZeroWord : bus.rom_inst_i;
         id_valid <= 1'b1;
         adel     <= misaligned;
      end
   end

   assign bus.if_excp_adel_o = adel;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc <= '0; id_inst <= ZeroWord; id_valid <= 1'b0;
      end else if (bubble) begin
         id_pc <= '0; id_inst <= ZeroWord; id_valid <= 1'b0;
      end else if (!bus.stall[StallIf]) begin
         id_pc    <= pc;
         id_inst  <= bus.rom_inst_i;
         id_valid <= 1'b1;
      end
   end
`endif

   assign bus.rom_addr_o = pc;
   assign bus.rom_en_o   = rom_en;
   assign bus.id_pc_o    = id_pc;
   assign bus.id_inst_o  = id_inst;
   assign bus.id_valid_o = id_valid;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-step expectations go through a scoreboard queue.
module tb_if_fetch;
   import if_fetch_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic        en;
      logic [31:0] id_pc;
      logic [31:0] id_inst;
      logic        id_valid;
      logic        adel;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   exp_t sb[$];

   if_fetch_if #(.ADDR_W(32)) bus ();
   if_fetch_if #(.ADDR_W(32)) bus_top ();

   if_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
   if_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_top (.clk(clk), .rst(rst), .bus(bus_top));

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [InstMemNumLog2-1:0] idx;
      idx = a[InstMemNumLog2+1:2];
      return {6'h2A, 16'(idx), 10'(idx) ^ 10'h155};
   endfunction

   assign bus.rom_inst_i     = rom_word(bus.rom_addr_o);
   assign bus_top.rom_inst_i = rom_word(bus_top.rom_addr_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_front(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, ".addr"},  bus.rom_addr_o, e.addr);
      chk({tag, ".en"},    32'(bus.rom_en_o), 32'(e.en));
      chk({tag, ".idpc"},  bus.id_pc_o, e.id_pc);
      chk({tag, ".inst"},  bus.id_inst_o, e.id_inst);
      chk({tag, ".valid"}, 32'(bus.id_valid_o), 32'(e.id_valid));
`ifdef FETCH_ALIGN_CHECK_EN
      chk({tag, ".adel"},  32'(bus.if_excp_adel_o), 32'(e.adel));
`endif
   endtask

   // Drive one cycle of stimulus, queue the expected post-edge state, then check it.
   task automatic step(input string tag, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt,
                       input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_idpc);
      exp_t e;
      bus.stall = st; bus.flush = fl; bus.new_pc = npc;
      bus.branch_flag_i = br; bus.branch_target_i = tgt;
      e.addr     = e_addr;
      e.en       = 1'b1;
      e.id_valid = e_vld;
      e.id_pc    = e_vld ? e_idpc : 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      e.adel     = e_vld && (e_idpc[1:0] != 2'b00);
      e.id_inst  = (e_vld && !e.adel) ? rom_word(e_idpc) : 32'h0;
`else
      e.adel     = 1'b0;
      e.id_inst  = e_vld ? rom_word(e_idpc) : 32'h0;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_front(tag);
   endtask

   initial begin
      exp_t r;
      bus.stall = '0; bus.flush = 1'b0; bus.new_pc = '0;
      bus.branch_flag_i = 1'b0; bus.branch_target_i = '0;
      bus_top.stall = '0; bus_top.flush = 1'b0; bus_top.new_pc = '0;
      bus_top.branch_flag_i = 1'b0; bus_top.branch_target_i = '0;

      r = '{addr: 32'h0, en: 1'b0, id_pc: 32'h0, id_inst: 32'h0, id_valid: 1'b0, adel: 1'b0};
      #12;
      sb.push_back(r);
      compare_front("reset");
      chk("top.reset_addr", bus_top.rom_addr_o, 32'hFFFF_FFF8);
      rst = 1'b0;

      //    tag      stall      fl  new_pc        br  target        addr          vld   id_pc
      step("rel",   6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1'b0, 32'h0);
      chk("top.seq0", bus_top.rom_addr_o, 32'hFFFF_FFF8);
      step("seq1",  6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1'b1, 32'h0);
      chk("top.seq1", bus_top.rom_addr_o, 32'hFFFF_FFFC);
      step("seq2",  6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1'b1, 32'h4);
      chk("top.wrap", bus_top.rom_addr_o, 32'h0000_0000);
      step("br",    6'b000000, 0, 32'h0,        1, 32'h100,      32'h0000_0100, 1'b1, 32'h8);
      step("br+1",  6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1'b1, 32'h100);
      step("seq3",  6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0108, 1'b1, 32'h104);
      step("hold1", 6'b000111, 0, 32'h0,        0, 32'h0,        32'h0000_0108, 1'b1, 32'h104);
      step("hold2", 6'b000111, 0, 32'h0,        0, 32'h0,        32'h0000_0108, 1'b1, 32'h104);
      step("stbub", 6'b000011, 0, 32'h0,        0, 32'h0,        32'h0000_0108, 1'b0, 32'h0);
      step("resume",6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_010C, 1'b1, 32'h108);
      step("flush", 6'b000011, 1, 32'h180,      1, 32'h300,      32'h0000_0180, 1'b0, 32'h0);
      step("fl+1",  6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0184, 1'b1, 32'h180);
      step("brstl", 6'b000001, 0, 32'h0,        1, 32'h200,      32'h0000_0184, 1'b1, 32'h184);
      step("brst+1",6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0188, 1'b1, 32'h184);
      step("misal", 6'b000000, 1, 32'h102,      0, 32'h0,        32'h0000_0102, 1'b0, 32'h0);
      step("mis+1", 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_0106, 1'b1, 32'h102);
      step("mis+2", 6'b000000, 0, 32'h0,        0, 32'h0,        32'h0000_010A, 1'b1, 32'h106);

      // Asynchronous reset mid-run, checked before any further clock edge.
      #2 rst = 1'b1;
      #1;
      sb.push_back(r);
      compare_front("areset");
      chk("top.areset", bus_top.rom_addr_o, 32'hFFFF_FFF8);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
